// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall, bubble, flush, freeze and forwarding control for a 5-stage MIPS pipeline
module hazard_ctrl #(
    parameter int MEM_LAT = 2,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             idex_mem_read,
    input  logic [4:0]       idex_rs,
    input  logic [4:0]       idex_rt,
    input  logic [4:0]       ifid_rs,
    input  logic [4:0]       ifid_rt,
    input  logic             id_uses_rt,
    input  logic             branch_taken,
    input  logic             exmem_mem_req,
    input  logic             exmem_reg_write,
    input  logic [4:0]       exmem_rd,
    input  logic             memwb_reg_write,
    input  logic [4:0]       memwb_rd,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             pipe_hold,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_count
);
    typedef enum logic {RUN, MEM_WAIT} state_t;
    // The first frozen cycle is spent in RUN, so MEM_WAIT covers the remaining MEM_LAT-2 cycles.
    localparam int CW = MEM_LAT > 3 ? $clog2(MEM_LAT - 2) : 1;
    localparam logic [CW-1:0] CNT_START = CW'(MEM_LAT > 2 ? MEM_LAT - 3 : 0);
    state_t st;
    logic [CW-1:0] cnt;
    logic done;
    logic lu, freeze, hold_all;
    logic ex_a, mw_a, ex_b, mw_b;
    assign lu = idex_mem_read && idex_rt != 5'd0 &&
                (idex_rt == ifid_rs || (id_uses_rt && idex_rt == ifid_rt));
    assign freeze = st == RUN && exmem_mem_req && !done && MEM_LAT > 1;
    assign hold_all = st == MEM_WAIT || freeze;
    assign ex_a = exmem_reg_write && exmem_rd != 5'd0 && exmem_rd == idex_rs;
    assign mw_a = memwb_reg_write && memwb_rd != 5'd0 && memwb_rd == idex_rs;
    assign ex_b = exmem_reg_write && exmem_rd != 5'd0 && exmem_rd == idex_rt;
    assign mw_b = memwb_reg_write && memwb_rd != 5'd0 && memwb_rd == idex_rt;
    assign fwd_a = rst ? 2'b00 : ex_a ? 2'b10 : mw_a ? 2'b01 : 2'b00;
    assign fwd_b = rst ? 2'b00 : ex_b ? 2'b10 : mw_b ? 2'b01 : 2'b00;
    // Pipeline control by priority: reset, freeze, taken branch, load-use, normal flow
    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        pipe_hold   = 1'b0;
        if (rst) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
        end else if (hold_all) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            pipe_hold  = 1'b1;
        end else if (branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (lu) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
        end
    end
    // Freeze sequencer; done masks the access for one RUN cycle so it cannot re-freeze as it leaves MEM
    always_ff @(posedge clk) begin
        if (rst) begin
            st   <= RUN;
            cnt  <= '0;
            done <= 1'b0;
        end else if (st == MEM_WAIT) begin
            if (cnt != '0) begin
                cnt <= cnt - CW'(1);
            end else begin
                st   <= RUN;
                done <= 1'b1;
            end
        end else if (freeze) begin
            if (MEM_LAT == 2) begin
                done <= 1'b1;
            end else begin
                st   <= MEM_WAIT;
                cnt  <= CNT_START;
                done <= 1'b0;
            end
        end else begin
            done <= 1'b0;
        end
    end
    // Saturating count of cycles in which the PC did not advance
    always_ff @(posedge clk) begin
        if (rst) stall_count <= '0;
        else if (!pc_write && stall_count != '1) stall_count <= stall_count + CNT_W'(1);
    end
endmodule
